gemm_seq: RTL and testbench

GEMM_SEQ -- requirements
Module: gemm_seq

---
 rtl/gemm_pkg.sv | 17 +
 rtl/gemm_lat_pipe.sv | 29 ++
 rtl/gemm_seq.sv | 151 +++++++++++++++
 tb/tb_gemm_seq.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared types and default sizing for the sequential GEMM controller.
package gemm_pkg;

  localparam int DEF_VEC_N    = 8;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_NUM_MACS = 2;
  localparam int DEF_DIM_W    = 8;
  localparam int DEF_MAC_LAT  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUT
  } state_t;

endpackage

// File: rtl/gemm_lat_pipe.sv
// Tracks in-flight MAC requests: a bit enters on accept and emerges DEPTH cycles later.
module gemm_lat_pipe
  import gemm_pkg::*;
#(
  parameter int DEPTH = DEF_MAC_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic valid,
  output logic empty
);

  logic [DEPTH-1:0] sr;

  // NOTE: the shift register is reset so a job aborted mid-flight leaves no phantom results behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else begin
      sr[0] <= push;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign valid = sr[DEPTH-1];
  assign empty = (sr == '0);

endmodule

// File: rtl/gemm_seq.sv
// Sequential GEMM controller: issues K operand-chunk requests per C element,
// accumulates the returned vec_mac results and hands out C in row-major order.
module gemm_seq
  import gemm_pkg::*;
#(
  parameter int VEC_N    = DEF_VEC_N,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_MACS = DEF_NUM_MACS,
  parameter int DIM_W    = DEF_DIM_W,
  parameter int MAC_LAT  = DEF_MAC_LAT,
  parameter int ACC_W    = 2*WIDTH + DIM_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIM_W-1:0]        cfg_m,
  input  logic [DIM_W-1:0]        cfg_n,
  input  logic [DIM_W-1:0]        cfg_k,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DIM_W-1:0]        rd_row,
  output logic [DIM_W-1:0]        rd_col,
  output logic [DIM_W-1:0]        rd_kidx,
  input  logic signed [2*WIDTH-1:0] mac_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [DIM_W-1:0]        out_row,
  output logic [DIM_W-1:0]        out_col
);

  if (MAC_LAT < 1 || VEC_N < 1 || NUM_MACS < 1 || ACC_W < 2*WIDTH) begin : g_bad_param
    $error("gemm_seq: illegal parameter combination");
  end

  state_t                  state;
  logic [DIM_W-1:0]        m_q, n_q, k_q;
  logic [DIM_W-1:0]        row, col, kidx;
  logic signed [ACC_W-1:0] acc;
  logic                    accept, mac_valid, pipe_empty, cfg_zero;

  assign accept   = (state == S_ISSUE) && rd_valid && rd_ready;
  assign cfg_zero = (cfg_m == '0) || (cfg_n == '0) || (cfg_k == '0);

  assign rd_row  = row;
  assign rd_col  = col;
  assign rd_kidx = kidx;
  assign out_row = row;
  assign out_col = col;

  gemm_lat_pipe #(.DEPTH(MAC_LAT)) u_lat_pipe (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .valid (mac_valid),
    .empty (pipe_empty)
  );

  // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      out_valid <= 1'b0;
      m_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      row       <= '0;
      col       <= '0;
      kidx      <= '0;
      acc       <= '0;
      out_data  <= '0;
    end else begin
      done <= 1'b0;
      // Results can only arrive in ISSUE/DRAIN; the size cast sign-extends and the add wraps.
      if (mac_valid) acc <= acc + ACC_W'(mac_result);

      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_zero) begin
              done <= 1'b1;
            end else begin
              m_q      <= cfg_m;
              n_q      <= cfg_n;
              k_q      <= cfg_k;
              row      <= '0;
              col      <= '0;
              kidx     <= '0;
              acc      <= '0;
              busy     <= 1'b1;
              rd_valid <= 1'b1;
              state    <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (accept) begin
            kidx <= kidx + 1'b1;
            if (kidx == k_q - 1'b1) begin
              rd_valid <= 1'b0;
              state    <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          // Empty means the final result was already folded in on the previous edge.
          if (pipe_empty) begin
            out_data  <= acc;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            kidx      <= '0;
            if (col == n_q - 1'b1) begin
              col <= '0;
              if (row == m_q - 1'b1) begin
                row   <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_IDLE;
              end else begin
                row      <= row + 1'b1;
                rd_valid <= 1'b1;
                state    <= S_ISSUE;
              end
            end else begin
              col      <= col + 1'b1;
              rd_valid <= 1'b1;
              state    <= S_ISSUE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_seq.sv
// Self-checking bench for gemm_seq: a vec_mac stand-in returns table values MAC_LAT
// cycles after each accepted request, and C is predicted as plain sums over that table.
module tb_gemm_seq;

  localparam int DIM_W   = 8;
  localparam int WIDTH   = 16;
  localparam int MAC_LAT = 4;
  localparam int ACC_W   = 2*WIDTH + DIM_W;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [DIM_W-1:0]          cfg_m, cfg_n, cfg_k;
  logic                      start;
  logic                      busy, done;
  logic                      rd_valid, rd_ready;
  logic [DIM_W-1:0]          rd_row, rd_col, rd_kidx;
  logic signed [2*WIDTH-1:0] mac_result;
  logic                      out_valid, out_ready;
  logic signed [ACC_W-1:0]   out_data;
  logic [DIM_W-1:0]          out_row, out_col;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gemm_seq #(
    .VEC_N(8), .WIDTH(WIDTH), .NUM_MACS(2), .DIM_W(DIM_W), .MAC_LAT(MAC_LAT), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .start(start), .busy(busy), .done(done),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_row(rd_row), .rd_col(rd_col), .rd_kidx(rd_kidx),
    .mac_result(mac_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col)
  );

  // Operand table: the vec_mac result for chunk (row, col, k).
  logic signed [2*WIDTH-1:0] val_tab [int];
  logic signed [2*WIDTH-1:0] due [int];

  typedef struct {int row; int col; int k;} req_t;
  typedef struct {int row; int col; logic signed [ACC_W-1:0] data;} res_t;
  req_t req_log [$];
  res_t out_log [$];

  int cyc = 0;
  int done_cnt = 0;
  int rd_valid_seen = 0;
  int hold_err = 0;

  function automatic int key(input int r, input int c, input int k);
    return (r << 16) | (c << 8) | k;
  endfunction

  function automatic logic signed [ACC_W-1:0] ref_elem(input int r, input int c, input int k);
    logic signed [ACC_W-1:0] s;
    s = '0;
    for (int i = 0; i < k; i++)
      if (val_tab.exists(key(r, c, i))) s = s + ACC_W'(val_tab[key(r, c, i)]);
    return s;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor and vec_mac stand-in; samples settled values between negedge and the next posedge.
  bit p_rd_stall = 0, p_out_stall = 0;
  logic [DIM_W-1:0] s_row, s_col, s_k, s_orow, s_ocol;
  logic signed [ACC_W-1:0] s_data;
  always @(negedge clk) begin
    #1;
    if (p_rd_stall && (rd_valid !== 1'b1 || rd_row !== s_row || rd_col !== s_col || rd_kidx !== s_k))
      hold_err++;
    if (p_out_stall && (out_valid !== 1'b1 || out_data !== s_data || out_row !== s_orow || out_col !== s_ocol))
      hold_err++;
    p_rd_stall  = rst && rd_valid && !rd_ready;
    p_out_stall = rst && out_valid && !out_ready;
    s_row = rd_row; s_col = rd_col; s_k = rd_kidx;
    s_orow = out_row; s_ocol = out_col; s_data = out_data;
    if (rd_valid === 1'b1) rd_valid_seen++;
    if (done === 1'b1) done_cnt++;
    if (rst && rd_valid && rd_ready) begin
      req_log.push_back('{int'(rd_row), int'(rd_col), int'(rd_kidx)});
      due[cyc + 1 + MAC_LAT] = val_tab.exists(key(int'(rd_row), int'(rd_col), int'(rd_kidx))) ?
                               val_tab[key(int'(rd_row), int'(rd_col), int'(rd_kidx))] : '0;
    end
    if (rst && out_valid && out_ready) out_log.push_back('{int'(out_row), int'(out_col), out_data});
    mac_result = due.exists(cyc + 1) ? due[cyc + 1] : $signed($urandom);
  end

  task automatic fill_rand(input int m, input int n, input int k);
    val_tab.delete();
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++)
        for (int i = 0; i < k; i++) val_tab[key(r, c, i)] = $signed($urandom);
  endtask

  task automatic run_job(input int m, input int n, input int k, input int rd_pct, input int out_pct,
                         input bit directed, input string name);
    bit finished;
    int ov_seen, bad, idx;
    logic signed [ACC_W-1:0] exp_v;
    req_log.delete();
    out_log.delete();
    hold_err = 0;
    @(negedge clk);
    done_cnt = 0;
    cfg_m = DIM_W'(m); cfg_n = DIM_W'(n); cfg_k = DIM_W'(k);
    start = 1'b1; rd_ready = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cfg_m = DIM_W'($urandom); cfg_n = DIM_W'($urandom); cfg_k = DIM_W'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_start: busy=%b done=%b, required busy=1 done=0", name, busy, done);
    end
    finished = 0; ov_seen = 0;
    for (int it = 0; it < 4000; it++) begin
      if (done === 1'b1) begin finished = 1; break; end
      if (directed) begin
        rd_ready = (it >= 3);
        if (out_valid === 1'b1) ov_seen++;
        out_ready = (ov_seen > 5);
      end else begin
        rd_ready  = ($urandom_range(99) < rd_pct);
        out_ready = ($urandom_range(99) < out_pct);
      end
      start = busy && ($urandom_range(7) == 0);
      @(negedge clk);
    end
    start = 1'b0; rd_ready = 1'b0; out_ready = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: done never seen within 4000 cycles, required done pulse", name);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: pulses=%0d busy=%b done=%b, required pulses=1 busy=0 done=0",
               name, done_cnt, busy, done);
    end
    checks++;
    if (out_log.size() != m*n) begin
      errors++;
      $display("FAIL %s out_count: got %0d, required %0d", name, out_log.size(), m*n);
    end
    idx = 0;
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        exp_v = ref_elem(r, c, k);
        checks++;
        if (idx >= out_log.size() || out_log[idx].row != r || out_log[idx].col != c ||
            out_log[idx].data !== exp_v) begin
          errors++;
          if (idx < out_log.size())
            $display("FAIL %s elem%0d: got (%0d,%0d)=%0d, required (%0d,%0d)=%0d", name, idx,
                     out_log[idx].row, out_log[idx].col, out_log[idx].data, r, c, exp_v);
          else
            $display("FAIL %s elem%0d: missing, required (%0d,%0d)=%0d", name, idx, r, c, exp_v);
        end
        idx++;
      end
    bad = (req_log.size() != m*n*k) ? 1 : 0;
    idx = 0;
    for (int r = 0; r < m && bad == 0; r++)
      for (int c = 0; c < n; c++)
        for (int i = 0; i < k; i++) begin
          if (req_log[idx].row != r || req_log[idx].col != c || req_log[idx].k != i) bad++;
          idx++;
        end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s req_order: %0d requests with %0d out of order, required %0d row-major",
               name, req_log.size(), bad, m*n*k);
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL %s hold_stable: %0d changes while stalled, required 0", name, hold_err);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({busy, done, rd_valid, out_valid} !== 4'b0 || out_data !== '0 ||
        rd_row !== '0 || rd_col !== '0 || rd_kidx !== '0 || out_row !== '0 || out_col !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b rd_valid=%b out_valid=%b out_data=%0d row=%0d col=%0d k=%0d, required all 0",
               name, busy, done, rd_valid, out_valid, out_data, rd_row, rd_col, rd_kidx);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; rd_ready = 1'b0; out_ready = 1'b0;
    cfg_m = '0; cfg_n = '0; cfg_k = '0; mac_result = '0;
    #12;
    check_all_zero("reset_asserted");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_released");
  endtask

  task automatic test_single;
    int a[8] = '{5, 7, 4, 1, 9, 2, 3, 6};
    int b[8] = '{3, 2, 6, 8, 0, 5, 7, 4};
    int dot;
    dot = 0;
    for (int lane = 0; lane < 2; lane++)
      for (int i = 0; i < 8; i++) dot += a[i] * b[i];
    val_tab.delete();
    val_tab[key(0, 0, 0)] = dot;
    run_job(1, 1, 1, 100, 100, 0, "single_232");
    checks++;
    if (out_log.size() != 1 || out_log[0].data !== ACC_W'(232)) begin
      errors++;
      $display("FAIL single_value: got %0d, required 232", out_log.size() ? out_log[0].data : 'x);
    end
  endtask

  task automatic test_k3;
    val_tab.delete();
    val_tab[key(0, 0, 0)] = 232;
    val_tab[key(0, 0, 1)] = -100;
    val_tab[key(0, 0, 2)] = 5;
    run_job(1, 1, 3, 100, 100, 0, "k3_sum");
    checks++;
    if (out_log.size() != 1 || out_log[0].data !== ACC_W'(137)) begin
      errors++;
      $display("FAIL k3_value: got %0d, required 137", out_log.size() ? out_log[0].data : 'x);
    end
  endtask

  task automatic test_order;
    fill_rand(2, 2, 1);
    run_job(2, 2, 1, 100, 100, 0, "order_2x2");
  endtask

  task automatic test_stall;
    fill_rand(1, 1, 2);
    run_job(1, 1, 2, 0, 0, 1, "stall_directed");
    fill_rand(3, 2, 3);
    run_job(3, 2, 3, 40, 30, 0, "stall_random");
  endtask

  task automatic test_zero_cfg(input int m, input int n, input int k, input string name);
    int seen0;
    @(negedge clk);
    cfg_m = DIM_W'(m); cfg_n = DIM_W'(n); cfg_k = DIM_W'(k);
    start = 1'b1; rd_ready = 1'b1; out_ready = 1'b1;
    seen0 = rd_valid_seen;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_next: done=%b busy=%b, required done=1 busy=0", name, done, busy);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt != 1 || rd_valid_seen != seen0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s no_issue: done pulses=%0d rd_valid cycles=%0d, required 1 and 0",
               name, done_cnt, rd_valid_seen - seen0);
    end
    rd_ready = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_drain;
    bit found;
    val_tab.delete();
    val_tab[key(0, 0, 0)] = 1000;
    val_tab[key(0, 0, 1)] = 2000;
    @(negedge clk);
    cfg_m = 1; cfg_n = 1; cfg_k = 2; start = 1'b1; rd_ready = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (rd_valid === 1'b0 && busy === 1'b1 && out_valid === 1'b0) begin found = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_drain reach_drain: drain window not observed, required within 50 cycles");
    end
    rst = 1'b0;
    #1;
    check_all_zero("reset_drain_outputs");
    @(negedge clk);
    rst = 1'b1; rd_ready = 1'b0;
    val_tab.delete();
    val_tab[key(0, 0, 0)] = -77;
    run_job(1, 1, 1, 100, 100, 0, "after_reset");
  endtask

  task automatic test_random;
    int m, n, k;
    for (int j = 0; j < 4; j++) begin
      m = $urandom_range(3, 1); n = $urandom_range(3, 1); k = $urandom_range(4, 1);
      fill_rand(m, n, k);
      run_job(m, n, k, (j == 0) ? 100 : 60, (j == 0) ? 100 : 50, 0, $sformatf("random%0d", j));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_k3();
    test_order();
    test_stall();
    test_zero_cfg(2, 2, 0, "zero_k");
    test_zero_cfg(0, 3, 2, "zero_m");
    test_reset_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
